pixel_scanout: RTL and testbench

PIXEL_SCANOUT -- requirements
Module: pixel_scanout

---
 rtl/ramdac_pkg.sv | 52 +++++
 rtl/video_timing_counter.sv | 89 ++++++++
 rtl/pixel_scanout.sv | 151 +++++++++++++++
 tb/tb_pixel_scanout.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ramdac_pkg.sv
// ramdac_pkg -- shared definitions for the pixel scanout path.
//
// Holds the default VGA 640x480@60 timing, the derived line/frame totals,
// the RGB332 field layout of a FIFO word, the scanout FSM state type and
// the record carried by the first output pipeline stage.
package ramdac_pkg;

  // Default timing: horizontal in pixel clocks, vertical in lines.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // RGB332 layout of one pixel word: rrr_ggg_bb.
  localparam int PIXEL_W   = 8;
  localparam int RED_W     = 3;
  localparam int RED_LSB   = 5;
  localparam int GREEN_W   = 3;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_W    = 2;
  localparam int BLUE_LSB  = 0;

  typedef enum logic {
    WAIT_FILL = 1'b0,  // idle: counters parked at 0, outputs blanked
    RUN       = 1'b1   // scanning frames
  } scan_state_e;

  // Per-position information travelling alongside the FIFO read latency.
  typedef struct packed {
    logic visible;  // position was inside the visible window
    logic hsync_n;  // raw horizontal sync, active-low
    logic vsync_n;  // raw vertical sync, active-low
    logic popped;   // a word was popped for this position
  } scan_stage_t;

  localparam scan_stage_t STAGE_IDLE = '{visible: 1'b0, hsync_n: 1'b1,
                                         vsync_n: 1'b1, popped: 1'b0};

  // Counter width able to hold 0..total-1.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter -- horizontal/vertical raster position generator.
//
// Ports:
//   clockin      pixel clock
//   reset        synchronous, active-high; parks the position at (0,0)
//   count_en     1: advance one pixel per clock; 0: hold position at (0,0)
//   visible      current position lies inside the visible window
//   hsync_raw_n  undelayed horizontal sync for the current position, active-low
//   vsync_raw_n  undelayed vertical sync for the current position, active-low
//   frame_last   current position is the last pixel of the frame
module video_timing_counter
  import ramdac_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic clockin,
  input  logic reset,
  input  logic count_en,
  output logic visible,
  output logic hsync_raw_n,
  output logic vsync_raw_n,
  output logic frame_last
);

  localparam int LINE_CLOCKS = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W = cnt_width(LINE_CLOCKS);
  localparam int V_W = cnt_width(FRAME_LINES);

  localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [H_W-1:0] H_LAST     = H_W'(LINE_CLOCKS - 1);
  localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(FRAME_LINES - 1);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           h_last;
  logic           v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!count_en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + V_W'(1);
    end else begin
      h_d = h_q + H_W'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge like any other input, so it
  // sits inside the clocked block rather than in the sensitivity list.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clockin) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign visible     = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hsync_raw_n = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
  assign vsync_raw_n = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
  assign frame_last  = h_last && v_last;

endmodule

// File: rtl/pixel_scanout.sv
// pixel_scanout -- streams RGB332 pixels from an upstream FIFO onto a
// VGA-style raster with registered colour, sync and active outputs.
//
// Ports:
//   clockin          pixel clock, all logic on its rising edge
//   reset            synchronous, active-high
//   enable           scanout enable; start and stop only at frame boundaries
//   fifo_data        pixel word, valid the cycle after fifo_read
//   fifo_empty       upstream FIFO empty flag
//   fifo_read        pop request, combinational from the current position
//   red/green/blue   colour fields of the displayed pixel (0 when blanked)
//   hsync/vsync      active-low syncs, aligned with the colour outputs
//   active           colour outputs carry a visible-area pixel
//   underflow        sticky: a visible pixel found the FIFO empty
//   underflow_clear  clears underflow; a simultaneous new underflow wins
//
// Pipeline: position decoded in cycle t, word arrives in t+1, pins update
// for t+2. Syncs/active travel through the same two stages.
module pixel_scanout
  import ramdac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK
) (
  input  logic                  clockin,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [RED_W-1:0]      red,
  output logic [GREEN_W-1:0]    green,
  output logic [BLUE_W-1:0]     blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  underflow,
  input  logic                  underflow_clear
);

  scan_state_e state_q, state_d;
  scan_stage_t s1_q, s1_d;
  logic [PIXEL_W-1:0] pix_q, pix_d;
  logic               active_q, active_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               underflow_q, underflow_d;

  logic               run;
  logic               visible;
  logic               hsync_raw_n;
  logic               vsync_raw_n;
  logic               frame_last;
  logic               starve;
  logic [PIXEL_W-1:0] pixel_word;

  assign run        = (state_q == RUN);
  assign pixel_word = fifo_data[PIXEL_W-1:0];

  video_timing_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clockin     (clockin),
    .reset       (reset),
    .count_en    (run),
    .visible     (visible),
    .hsync_raw_n (hsync_raw_n),
    .vsync_raw_n (vsync_raw_n),
    .frame_last  (frame_last)
  );

  // Pop only for visible positions with data available. Gating with reset
  // keeps the FIFO intact when reset lands mid-frame.
  assign fifo_read = run && visible && !fifo_empty && !reset;
  assign starve    = run && visible && fifo_empty;

  // Scanout FSM: start as soon as enabled with data waiting; stop only
  // after the last pixel of a frame so a frame is never truncated.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FILL: if (enable && !fifo_empty) state_d = RUN;
      RUN:       if (frame_last && !enable) state_d = WAIT_FILL;
      default:   state_d = WAIT_FILL;
    endcase
  end

  always_comb begin
    // Stage 1 records what the current position needs once its word lands.
    s1_d = STAGE_IDLE;
    if (run) begin
      s1_d = '{visible: visible, hsync_n: hsync_raw_n,
               vsync_n: vsync_raw_n, popped: fifo_read};
    end

    // Stage 2: a starved or blanked position shows black; a starved pixel
    // is simply skipped, so later pixels keep their own words.
    pix_d    = s1_q.popped ? pixel_word : '0;
    active_d = s1_q.visible;
    hsync_d  = s1_q.hsync_n;
    vsync_d  = s1_q.vsync_n;

    // Clear first, set second: a fresh underflow beats a clear request.
    underflow_d = underflow_q;
    if (underflow_clear) underflow_d = 1'b0;
    if (starve)          underflow_d = 1'b1;
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      state_q     <= WAIT_FILL;
      s1_q        <= STAGE_IDLE;
      pix_q       <= '0;
      active_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      pix_q       <= pix_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      underflow_q <= underflow_d;
    end
  end

  assign red       = pix_q[RED_LSB   +: RED_W];
  assign green     = pix_q[GREEN_LSB +: GREEN_W];
  assign blue      = pix_q[BLUE_LSB  +: BLUE_W];
  assign active    = active_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pixel_scanout.sv
// tb_pixel_scanout -- directed bench for pixel_scanout on a reduced raster
// (line 120+4+8+4 = 136 clocks, frame 8+1+2+1 = 12 lines) so whole frames
// stay short. A small FIFO model pops word_of(n) for the n-th read.
module tb_pixel_scanout;

  localparam int HT    = 136;
  localparam int FRAME = HT * 12;      // 1632 clocks
  localparam int U0    = 5 * HT + 100; // line 5, pixel 100

  logic       clockin = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_read;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       underflow;
  logic       underflow_clear;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;

  pixel_scanout #(
    .DATA_WIDTH (8),
    .H_VISIBLE  (120), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
    .V_VISIBLE  (8),   .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut (
    .clockin         (clockin),
    .reset           (reset),
    .enable          (enable),
    .fifo_data       (fifo_data),
    .fifo_empty      (fifo_empty),
    .fifo_read       (fifo_read),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .hsync           (hsync),
    .vsync           (vsync),
    .active          (active),
    .underflow       (underflow),
    .underflow_clear (underflow_clear)
  );

  always #5 clockin = ~clockin;

  // Word n of the stream; word 10 is the E3 test colour.
  function automatic logic [7:0] word_of(input int n);
    if (n == 10) return 8'hE3;
    return 8'(n * 37 + 5);
  endfunction

  // FIFO dataout: the popped word is presented the cycle after the pop.
  always @(posedge clockin) begin
    if (fifo_read) begin
      fifo_data <= word_of(pop_cnt);
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clockin);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},       {red, green, blue}, 8'h00);
    check({tag, "_active"},    active,    1'b0);
    check({tag, "_hsync"},     hsync,     1'b1);
    check({tag, "_vsync"},     vsync,     1'b1);
    check({tag, "_underflow"}, underflow, 1'b0);
    check({tag, "_fifo_read"}, fifo_read, 1'b0);
  endtask

  initial begin
    int pops, acts, hs_low, vs_low, pops2;
    pops = 0; acts = 0; hs_low = 0; vs_low = 0; pops2 = 0;

    // Reset state.
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; underflow_clear = 1'b0;
    repeat (3) tick();
    settle();
    check_reset_outputs("reset");

    // Enabled but FIFO empty: must stay idle.
    tick();
    reset = 1'b0; enable = 1'b1;
    repeat (3) tick();
    settle();
    check("idle_empty_no_pop", fifo_read, 1'b0);
    check("idle_empty_active", active, 1'b0);

    // Data arrives: this cycle is still WAIT_FILL, next one is RUN at (0,0).
    tick();
    fifo_empty = 1'b0;
    settle();
    check("wait_fill_no_pop", fifo_read, 1'b0);

    // Frame 1, FIFO never empty. Loop index k = position cycle since RUN;
    // outputs seen at k show position k-2.
    for (int k = 0; k < FRAME + 2; k++) begin
      tick();
      settle();
      if (k < FRAME && fifo_read) pops++;
      if (k >= FRAME && fifo_read) pops2++;
      if (k >= 2) begin
        if (active) acts++;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (k == 0)   check("first_pop", fifo_read, 1'b1);
      if (k == 1)   check("pipe_not_active_yet", active, 1'b0);
      if (k == 2)   check("word0_rgb", {red, green, blue}, 8'h05);
      if (k == 2)   check("word0_active", active, 1'b1);
      if (k == 12) begin
        check("e3_red", red, 3'd7);
        check("e3_green", green, 3'd0);
        check("e3_blue", blue, 2'd3);
      end
      if (k == 120) check("no_pop_h120", fifo_read, 1'b0);
      if (k == 121) check("last_vis_rgb", {red, green, blue}, 8'h38);
      if (k == 122) check("blank_rgb", {red, green, blue}, 8'h00);
      if (k == 122) check("blank_active", active, 1'b0);
      if (k == 125) check("hsync_h123", hsync, 1'b1);
      if (k == 126) check("hsync_h124", hsync, 1'b0);
      if (k == 133) check("hsync_h131", hsync, 1'b0);
      if (k == 134) check("hsync_h132", hsync, 1'b1);
      if (k == 2 + HT) check("line1_px0_rgb", {red, green, blue}, 8'h5D);
      if (k == 2 + 9 * HT - 1) check("vsync_v8_end", vsync, 1'b1);
      if (k == 2 + 9 * HT)     check("vsync_v9_start", vsync, 1'b0);
      if (k == 2 + 11 * HT - 1) check("vsync_v10_end", vsync, 1'b0);
      if (k == 2 + 11 * HT)    check("vsync_v11", vsync, 1'b1);
    end
    check("frame_pops", pops, 960);
    check("frame_active_clocks", acts, 960);
    check("frame_hsync_low", hs_low, 96);
    check("frame_vsync_low", vs_low, 2 * HT);

    // Frame 2: starve pixels 100..103 of line 5, try a clear that collides
    // with a new underflow, then drop enable on line 6.
    for (int j = 2; j < FRAME + 4; j++) begin
      tick();
      fifo_empty      = (j >= U0 && j <= U0 + 3);
      underflow_clear = (j == U0 + 2);
      if (j == 6 * HT) enable = 1'b0;
      settle();
      if (j < FRAME && fifo_read) pops2++;
      if (j >= U0 && j <= U0 + 3) check("starve_no_pop", fifo_read, 1'b0);
      if (j == U0)     check("underflow_before", underflow, 1'b0);
      if (j == U0 + 1) check("underflow_set", underflow, 1'b1);
      if (j == U0 + 1) check("px99_rgb", {red, green, blue}, 8'hCC);
      if (j == U0 + 2) check("starve_px100_rgb", {red, green, blue}, 8'h00);
      if (j == U0 + 3) check("starve_active", active, 1'b1);
      if (j == U0 + 3) check("set_beats_clear", underflow, 1'b1);
      if (j == U0 + 5) check("starve_px103_rgb", {red, green, blue}, 8'h00);
      if (j == U0 + 6) check("px104_no_realign", {red, green, blue}, 8'hF1);
      if (j == 7 * HT) check("disabled_frame_continues", fifo_read, 1'b1);
      if (j == FRAME)  check("back_to_wait_fill", fifo_read, 1'b0);
      if (j == FRAME + 2) check("idle_after_stop_active", active, 1'b0);
      if (j == FRAME + 3) check("underflow_sticky", underflow, 1'b1);
    end
    // 960 visible pixels minus the 4 starved ones.
    check("frame2_pops", pops2, 956);

    // Clear pulse.
    tick();
    underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    settle();
    check("underflow_cleared", underflow, 1'b0);

    // Restart, then reset at line 6 pixel 60.
    tick();
    enable = 1'b1;
    settle();
    check("restart_wait_fill", fifo_read, 1'b0);
    for (int j = 0; j <= 6 * HT + 60; j++) begin
      tick();
      if (j == 6 * HT + 60) reset = 1'b1;
      settle();
      if (j == 0) check("restart_first_pop", fifo_read, 1'b1);
      if (j == 6 * HT + 60) begin
        check("pre_reset_active", active, 1'b1);
        check("reset_cycle_no_pop", fifo_read, 1'b0);
      end
    end
    tick();
    settle();
    check_reset_outputs("midframe_reset");

    // Release reset with enable still high: WAIT_FILL first, then (0,0).
    reset = 1'b0;
    settle();
    check("post_reset_wait_fill", fifo_read, 1'b0);
    tick();
    settle();
    check("post_reset_first_pop", fifo_read, 1'b1);
    check("post_reset_active", active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
